// File: rtl/alu_seq.sv
// Handshaked ALU: 8 legacy ops plus iterative shift-add MUL; ALU_SIGNED_OPS_EN adds SLT (9) / ASR (10).
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL; result/flags held until out_ready.
// Backpressure: in_ready low during MUL and in DONE while out_ready is low; same-cycle retire+accept.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             busy
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_NOT = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_LS  = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_RS  = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_AND = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_OR  = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_LT  = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(8);
`ifdef ALU_SIGNED_OPS_EN
  localparam logic [SEL_W-1:0] OP_SLT = SEL_W'(9);
  localparam logic [SEL_W-1:0] OP_ASR = SEL_W'(10);
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             shift_big;
  logic [SH_W-1:0]  sh;
  logic [WIDTH-1:0] acc_next;
  logic             last_iter;
`ifdef ALU_SIGNED_OPS_EN
  logic signed [WIDTH-1:0] asr_v;
`endif

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_MUL);
  assign accept    = in_valid && in_ready;

  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Unused select codes (and MUL, which never takes this path) fall back to ADD.
  always_comb begin
    sum       = {1'b0, alu_a} + {1'b0, alu_b};
    res       = sum[WIDTH-1:0];
    res_c     = sum[WIDTH];
    shift_big = (alu_b >= W_VAL);
    sh        = alu_b[SH_W-1:0];
`ifdef ALU_SIGNED_OPS_EN
    asr_v     = $signed(alu_a) >>> sh;
`endif
    case (alu_sel)
      OP_SUB: begin
        res   = alu_a - alu_b;
        res_c = (alu_a < alu_b);
      end
      OP_NOT: begin
        res   = ~alu_a;
        res_c = 1'b0;
      end
      OP_LS: begin
        res   = shift_big ? '0 : (alu_a << sh);
        res_c = 1'b0;
      end
      OP_RS: begin
        res   = shift_big ? '0 : (alu_a >> sh);
        res_c = 1'b0;
      end
      OP_AND: begin
        res   = alu_a & alu_b;
        res_c = 1'b0;
      end
      OP_OR: begin
        res   = alu_a | alu_b;
        res_c = 1'b0;
      end
      OP_LT: begin
        res   = WIDTH'(alu_a < alu_b);
        res_c = 1'b0;
      end
`ifdef ALU_SIGNED_OPS_EN
      OP_SLT: begin
        res   = WIDTH'($signed(alu_a) < $signed(alu_b));
        res_c = 1'b0;
      end
      OP_ASR: begin
        res   = shift_big ? {WIDTH{alu_a[WIDTH-1]}} : asr_v;
        res_c = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      alu_out <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_n  <= 1'b0;
    end else if (state == ST_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last_iter) begin
        alu_out <= acc_next;
        flag_z  <= (acc_next == '0);
        flag_c  <= 1'b0;
        flag_n  <= acc_next[WIDTH-1];
        state   <= ST_DONE;
      end
    end else if (accept) begin
      // Accepting from DONE retires the held result in the same edge.
      if (alu_sel == OP_MUL) begin
        mcand  <= alu_a;
        mplier <= alu_b;
        acc    <= '0;
        cnt    <= '0;
        state  <= ST_MUL;
      end else begin
        alu_out <= res;
        flag_z  <= (res == '0);
        flag_c  <= res_c;
        flag_n  <= res[WIDTH-1];
        state   <= ST_DONE;
      end
    end else if ((state == ST_DONE) && out_ready) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): vector table through a scoreboard plus hand-written MUL, stall and reset sequences.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic        flag_z;
  logic        flag_c;
  logic        flag_n;
  logic        busy;

  alu_seq #(.WIDTH(32), .SEL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        n;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic z, input logic c, input logic n);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.res = res; v.z = z; v.c = c; v.n = n;
    vecs.push_back(v);
  endtask

  task automatic expect_res(input logic [31:0] res, input logic z, input logic c, input logic n);
    vec_t v;
    v.sel = 4'd0; v.a = '0; v.b = '0; v.res = res; v.z = z; v.c = c; v.n = n;
    sb.push_back(v);
  endtask

  // Call away from a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    alu_sel  = sel;
    alu_a    = a;
    alu_b    = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never rose, sel=%0d", sel);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h with empty scoreboard", alu_out);
      end else begin
        vec_t e;
        e = sb.pop_front();
        check("result", {29'd0, alu_out, flag_z, flag_c, flag_n}, {29'd0, e.res, e.z, e.c, e.n});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  busy_cnt;
    logic mul_ok;
    logic hold_ok;

    add_vec(4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, 1, 0);
    add_vec(4'd1,  32'h3,         32'h5,         32'hFFFF_FFFE, 0, 1, 1);
    add_vec(4'd7,  32'h3,         32'h5,         32'h1,         0, 0, 0);
    add_vec(4'd2,  32'h0,         32'h0,         32'hFFFF_FFFF, 0, 0, 1);
    add_vec(4'd3,  32'h1,         32'd32,        32'h0,         1, 0, 0);
    add_vec(4'd4,  32'h8000_0000, 32'd31,        32'h1,         0, 0, 0);
    add_vec(4'd3,  32'h1,         32'd31,        32'h8000_0000, 0, 0, 1);
    add_vec(4'd4,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 0, 0);
    add_vec(4'd5,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 0);
    add_vec(4'd6,  32'hF0,        32'h0F,        32'hFF,        0, 0, 0);
    add_vec(4'd0,  32'h2,         32'h3,         32'h5,         0, 0, 0);
    add_vec(4'd1,  32'h5,         32'h5,         32'h0,         1, 0, 0);
    add_vec(4'd7,  32'h5,         32'h3,         32'h0,         1, 0, 0);
    add_vec(4'd15, 32'h7,         32'h8,         32'hF,         0, 0, 0);
`ifdef ALU_SIGNED_OPS_EN
    add_vec(4'd9,  32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0);
    add_vec(4'd10, 32'h8000_0000, 32'd4,         32'hF800_0000, 0, 0, 1);
    add_vec(4'd10, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 0, 0, 1);
`else
    add_vec(4'd9,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, 1, 0);
    add_vec(4'd10, 32'h8000_0000, 32'd4,         32'h8000_0004, 0, 0, 1);
    add_vec(4'd10, 32'h8000_0000, 32'd40,        32'h8000_0028, 0, 0, 1);
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_sel   = '0;
    alu_a     = '0;
    alu_b     = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_out_flags", {alu_out, flag_z, flag_c, flag_n}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      sb.push_back(vecs[i]);
      send(vecs[i].sel, vecs[i].a, vecs[i].b);
      check("latency1_valid", out_valid, 1);
      @(negedge clk);
    end

    // MUL with operand bus scrambled while iterating.
    expect_res(32'h0123_4500, 0, 0, 0);
    send(4'd8, 32'h0001_2345, 32'h0000_0100);
    busy_cnt = 0;
    mul_ok   = 1'b1;
    alu_a    = 32'hDEAD_BEEF;
    alu_b    = 32'h1234_5678;
    alu_sel  = 4'd0;
    while (busy_cnt < 100) begin
      @(negedge clk);
      if (out_valid) break;
      if (!busy || in_ready) mul_ok = 1'b0;
      busy_cnt++;
    end
    check("mul_busy_cycles", busy_cnt, 32);
    check("mul_busy_no_ready", mul_ok, 1);
    check("mul_done_busy_low", busy, 0);

    expect_res(32'h1, 0, 0, 0);
    send(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (40) @(negedge clk);
    expect_res(32'd42, 0, 0, 0);
    send(4'd8, 32'd7, 32'd6);
    repeat (40) @(negedge clk);

    // Stall in DONE, then retire and accept in the same cycle.
    out_ready = 1'b0;
    expect_res(32'hFFFF_FFFF, 0, 0, 1);
    send(4'd2, 32'h0, 32'h1234);
    hold_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || alu_out !== 32'hFFFF_FFFF || in_ready) hold_ok = 1'b0;
    end
    check("hold_stable", hold_ok, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    expect_res(32'hFF, 0, 0, 0);
    send(4'd6, 32'hF0, 32'h0F);
    check("b2b_no_bubble", {out_valid, alu_out}, {1'b1, 32'hFF});
    @(negedge clk);

    // Reset in the middle of a multiply.
    send(4'd8, 32'h0001_2345, 32'h0000_0100);
    repeat (10) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_alu_out", alu_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", in_ready, 1);
    expect_res(32'd4, 0, 0, 0);
    send(4'd0, 32'd2, 32'd2);
    check("post_rst_latency", out_valid, 1);
    repeat (3) @(negedge clk);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
